// File: rtl/button_color_selector.sv
// Debounced push button that steps an active-low RGB LED through six hues, with auto-repeat while held.
// Press-to-step latency is DEBOUNCE_CYCLES+3 clocks; no backpressure, one step pulse per press or repeat.
module button_color_selector #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int REPEAT_CYCLES   = 6000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_n,
    output logic       RGB_R,
    output logic       RGB_G,
    output logic       RGB_B,
    output logic [2:0] color_idx,
    output logic       step
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int RP_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RP_W-1:0] RP_LAST = RP_W'((REPEAT_CYCLES > 0) ? REPEAT_CYCLES - 1 : 0);
    localparam logic REP_EN = (REPEAT_CYCLES > 0);

    typedef enum logic [2:0] {
        RED     = 3'd0,
        YELLOW  = 3'd1,
        GREEN   = 3'd2,
        CYAN    = 3'd3,
        BLUE    = 3'd4,
        MAGENTA = 3'd5
    } color_e;

    logic            s1_q, s2_q;
    logic            stable_q, stable_d;
    logic            stable_prev_q;
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic [RP_W-1:0] rep_cnt_q, rep_cnt_d;
    color_e          color_q, color_d;
    logic            step_q;
    logic [2:0]      rgb_q, rgb_d;
    logic            press, rep_fire, step_evt;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = db_cnt_q;
        if (s2_q == stable_q) begin
            db_cnt_d = '0;
        end else if (db_cnt_q == DB_LAST) begin
            stable_d = s2_q;
            db_cnt_d = '0;
        end else begin
            db_cnt_d = db_cnt_q + 1'b1;
        end
    end

    // rep_cnt is held at zero while released, so a press and a repeat cannot coincide
    assign press    = stable_prev_q & ~stable_q;
    assign rep_fire = REP_EN & ~stable_q & (rep_cnt_q == RP_LAST);
    assign step_evt = press | rep_fire;

    always_comb begin
        rep_cnt_d = rep_cnt_q + 1'b1;
        if (stable_q || step_evt || !REP_EN) begin
            rep_cnt_d = '0;
        end
    end

    always_comb begin
        color_d = color_q;
        case (color_q)
            RED:     if (step_evt) color_d = YELLOW;
            YELLOW:  if (step_evt) color_d = GREEN;
            GREEN:   if (step_evt) color_d = CYAN;
            CYAN:    if (step_evt) color_d = BLUE;
            BLUE:    if (step_evt) color_d = MAGENTA;
            MAGENTA: if (step_evt) color_d = RED;
            default: color_d = RED;
        endcase

        // LED pins are active-low: drive the inverse of the {R,G,B} intent
        rgb_d = 3'b011;
        case (color_d)
            RED:     rgb_d = 3'b011;
            YELLOW:  rgb_d = 3'b001;
            GREEN:   rgb_d = 3'b101;
            CYAN:    rgb_d = 3'b100;
            BLUE:    rgb_d = 3'b110;
            MAGENTA: rgb_d = 3'b010;
            default: rgb_d = 3'b011;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= 1'b1;
            s2_q          <= 1'b1;
            stable_q      <= 1'b1;
            stable_prev_q <= 1'b1;
            db_cnt_q      <= '0;
            rep_cnt_q     <= '0;
            color_q       <= RED;
            step_q        <= 1'b0;
            rgb_q         <= 3'b011;
        end else begin
            s1_q          <= btn_n;
            s2_q          <= s1_q;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
            db_cnt_q      <= db_cnt_d;
            rep_cnt_q     <= rep_cnt_d;
            color_q       <= color_d;
            step_q        <= step_evt;
            rgb_q         <= rgb_d;
        end
    end

    assign color_idx           = color_q;
    assign step                = step_q;
    assign {RGB_R, RGB_G, RGB_B} = rgb_q;

endmodule
